// File: rtl/fir_xifu_mem_responder_if.sv
// Bundles the CORE-V-XIF memory request/response/result channels and the OBI
// data port of the FIR XIFU memory responder. slave = responder, master = environment.
interface fir_xifu_mem_responder_if #(
  parameter int X_ID_WIDTH = 4
);
  logic                  mem_valid_i;
  logic                  mem_ready_o;
  logic [X_ID_WIDTH-1:0] mem_id_i;
  logic [31:0]           mem_addr_i;
  logic                  mem_we_i;
  logic [2:0]            mem_size_i;
  logic [3:0]            mem_be_i;
  logic [31:0]           mem_wdata_i;
  logic                  mem_last_i;
  logic                  mem_resp_exc_o;
  logic [5:0]            mem_resp_exccode_o;
  logic                  mem_result_valid_o;
  logic [X_ID_WIDTH-1:0] mem_result_id_o;
  logic [31:0]           mem_result_rdata_o;
  logic                  mem_result_err_o;
  logic                  data_req_o;
  logic                  data_gnt_i;
  logic [31:0]           data_addr_o;
  logic                  data_we_o;
  logic [3:0]            data_be_o;
  logic [31:0]           data_wdata_o;
  logic                  data_rvalid_i;
  logic [31:0]           data_rdata_i;
  logic                  data_err_i;

  modport slave (
    input  mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i,
           mem_wdata_i, mem_last_i,
    output mem_ready_o, mem_resp_exc_o, mem_resp_exccode_o,
           mem_result_valid_o, mem_result_id_o, mem_result_rdata_o, mem_result_err_o,
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  modport master (
    output mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i,
           mem_wdata_i, mem_last_i,
    input  mem_ready_o, mem_resp_exc_o, mem_resp_exccode_o,
           mem_result_valid_o, mem_result_id_o, mem_result_rdata_o, mem_result_err_o,
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );
endinterface

// File: rtl/fir_xifu_mem_responder.sv
// XIF memory responder: one coprocessor request at a time, executed on an OBI port.
// Optional region (PMA) check compiled in with FIR_XIFU_MEM_RESP_PMA_EN.
module fir_xifu_mem_responder #(
  parameter int          X_ID_WIDTH = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE  = 32'h0010_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  fir_xifu_mem_responder_if.slave        bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic                  abort_reg, abort_next;
  logic                  active_reg;
  logic [29:0]           addr_reg;
  logic                  we_reg;
  logic [3:0]            be_reg;
  logic [31:0]           wdata_reg;
  logic [X_ID_WIDTH-1:0] id_reg;
  logic                  res_valid_reg;
  logic [X_ID_WIDTH-1:0] res_id_reg;
  logic [31:0]           res_rdata_reg;
  logic                  res_err_reg;

  logic       is_half, is_word, misaligned, out_of_region, exc;
  logic [5:0] exc_code;
  logic       ready, handshake, accept, capture;

  // Unknown size encodings fall back to word alignment rules.
  assign is_half    = (bus.mem_size_i == 3'b010);
  assign is_word    = (bus.mem_size_i != 3'b001) && !is_half;
  assign misaligned = (is_word && (bus.mem_addr_i[1:0] != 2'b00)) ||
                      (is_half && bus.mem_addr_i[0]);

`ifdef FIR_XIFU_MEM_RESP_PMA_EN
  logic [31:0] offset;
  // Addresses below the base wrap to a large offset and fail the bound too.
  assign offset        = bus.mem_addr_i - ADDR_BASE;
  assign out_of_region = (offset >= ADDR_SIZE);
`else
  logic [31:0] unused_cfg;
  assign unused_cfg    = ADDR_BASE ^ ADDR_SIZE;
  assign out_of_region = 1'b0;
`endif

  logic unused_last;
  assign unused_last = bus.mem_last_i;

  assign exc      = misaligned || out_of_region;
  assign exc_code = misaligned ? (bus.mem_we_i ? 6'd6 : 6'd4)
                               : (bus.mem_we_i ? 6'd7 : 6'd5);

  assign ready     = active_reg && (state_reg == IDLE) && !clear_i;
  assign handshake = bus.mem_valid_i && ready;
  assign accept    = handshake && !exc;

  assign bus.mem_ready_o        = ready;
  assign bus.mem_resp_exc_o     = handshake && exc;
  assign bus.mem_resp_exccode_o = (handshake && exc) ? exc_code : 6'd0;

  always_comb begin
    state_next = state_reg;
    abort_next = abort_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        abort_next = 1'b0;
        if (accept) state_next = REQ;
      end
      REQ: begin
        // An OBI request cannot be withdrawn; remember the clear until grant.
        if (clear_i) abort_next = 1'b1;
        if (bus.data_gnt_i) state_next = (abort_reg || clear_i) ? DRAIN : RESP;
      end
      RESP: begin
        if (bus.data_rvalid_i) begin
          state_next = IDLE;
          capture    = !clear_i;
        end else if (clear_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.data_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      abort_reg     <= 1'b0;
      active_reg    <= 1'b0;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      id_reg        <= '0;
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      res_rdata_reg <= '0;
      res_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      abort_reg     <= abort_next;
      active_reg    <= 1'b1;
      res_valid_reg <= capture;
      if (accept) begin
        addr_reg  <= bus.mem_addr_i[31:2];
        we_reg    <= bus.mem_we_i;
        be_reg    <= bus.mem_be_i;
        wdata_reg <= bus.mem_wdata_i;
        id_reg    <= bus.mem_id_i;
      end
      if (capture) begin
        res_id_reg    <= id_reg;
        res_rdata_reg <= we_reg ? 32'h0 : bus.data_rdata_i;
        res_err_reg   <= bus.data_err_i;
      end
    end
  end

  assign bus.data_req_o   = (state_reg == REQ);
  assign bus.data_addr_o  = {addr_reg, 2'b00};
  assign bus.data_we_o    = we_reg;
  assign bus.data_be_o    = be_reg;
  assign bus.data_wdata_o = wdata_reg;

  assign bus.mem_result_valid_o = res_valid_reg;
  assign bus.mem_result_id_o    = res_id_reg;
  assign bus.mem_result_rdata_o = res_rdata_reg;
  assign bus.mem_result_err_o   = res_err_reg;

endmodule

// File: tb/tb_fir_xifu_mem_responder.sv
// Self-checking bench for fir_xifu_mem_responder: OBI memory slave, result monitor,
// and a word-level reference memory/exception model.
module tb_fir_xifu_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0010_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  fir_xifu_mem_responder_if #(.X_ID_WIDTH(4)) m ();

  fir_xifu_mem_responder #(.X_ID_WIDTH(4), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clear),
    .bus    (m)
  );

  initial forever #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int gnt_delay = 0, rvalid_delay = 0;
  logic err_inject = 1'b0;
  int req_count = 0, grant_count = 0, rvalid_count = 0;
  int stable_viol = 0, align_viol = 0;
  int result_count = 0, double_pulse = 0;
  logic [31:0] obi_mem [256];
  logic [31:0] ref_mem [256];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // OBI slave: grants after gnt_delay cycles of request, answers rvalid_delay cycles later.
  initial begin
    logic in_req, pend, pend_err;
    int gcnt, rcnt;
    logic [31:0] pend_rdata, mask;
    logic [68:0] snap;
    in_req = 0; pend = 0; pend_err = 0; gcnt = 0; rcnt = 0; pend_rdata = 0; snap = 0;
    m.data_gnt_i = 0; m.data_rvalid_i = 0; m.data_rdata_i = 0; m.data_err_i = 0;
    forever begin
      @(negedge clk);
      m.data_gnt_i = 0; m.data_rvalid_i = 0; m.data_rdata_i = 0; m.data_err_i = 0;
      if (!rst_n) begin
        in_req = 0; pend = 0;
      end else begin
        if (pend) begin
          if (rcnt == 0) begin
            m.data_rvalid_i = 1; m.data_rdata_i = pend_rdata; m.data_err_i = pend_err;
            pend = 0; rvalid_count++;
          end else rcnt--;
        end
        if (m.data_req_o) begin
          if (!in_req) begin
            in_req = 1; gcnt = gnt_delay; req_count++;
            snap = {m.data_addr_o, m.data_we_o, m.data_be_o, m.data_wdata_o};
            if (m.data_addr_o[1:0] != 2'b00) align_viol++;
          end else if (snap !== {m.data_addr_o, m.data_we_o, m.data_be_o, m.data_wdata_o})
            stable_viol++;
          if (gcnt == 0) begin
            m.data_gnt_i = 1; in_req = 0; grant_count++;
            mask = {{8{m.data_be_o[3]}}, {8{m.data_be_o[2]}}, {8{m.data_be_o[1]}}, {8{m.data_be_o[0]}}};
            if (m.data_we_o) begin
              obi_mem[m.data_addr_o[9:2]] = (obi_mem[m.data_addr_o[9:2]] & ~mask) | (m.data_wdata_o & mask);
              pend_rdata = $urandom;
            end else pend_rdata = obi_mem[m.data_addr_o[9:2]];
            pend = 1; rcnt = rvalid_delay; pend_err = err_inject;
          end else gcnt--;
        end
      end
    end
  end

  initial begin
    logic prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (m.mem_result_valid_o) begin
        result_count++;
        if (prev) double_pulse++;
      end
      prev = m.mem_result_valid_o;
    end
  end

  // Exception rules: alignment by access size first, then the optional region bound.
  function automatic void model_exc(input logic [31:0] a, input logic [2:0] sz, input logic we,
                                    output logic exc, output logic [5:0] code);
    int bytes;
    longint off;
    bytes = (sz == 3'b001) ? 1 : (sz == 3'b010) ? 2 : 4;
    off = longint'(a) - longint'(BASE);
    exc = 0; code = 0;
    if ((int'(a[1:0]) % bytes) != 0) begin
      exc = 1; code = we ? 6'd6 : 6'd4;
    end
`ifdef FIR_XIFU_MEM_RESP_PMA_EN
    else if (off < 0 || off >= longint'(SIZE)) begin
      exc = 1; code = we ? 6'd7 : 6'd5;
    end
`else
    if (off < 0) exc = exc;
`endif
  endfunction

  task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic we,
                         input logic [2:0] size, input logic [3:0] be, input logic [31:0] wdata,
                         input int gd, input int rd, input logic err, output int res_c);
    logic exp_exc, seen;
    logic [5:0] exp_code;
    logic [31:0] exp_rdata, mask;
    int hs_c, n, req0, res0;
    model_exc(addr, size, we, exp_exc, exp_code);
    gnt_delay = gd; rvalid_delay = rd; err_inject = err;
    m.mem_valid_i = 1; m.mem_id_i = id; m.mem_addr_i = addr; m.mem_we_i = we;
    m.mem_size_i = size; m.mem_be_i = be; m.mem_wdata_i = wdata; m.mem_last_i = 1;
    #1;
    n = 0;
    while (!m.mem_ready_o && n < 20) begin @(negedge clk); #1; n++; end
    hs_c = cyc;
    tests_run++;
    if (m.mem_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL ready: got %b want 1", m.mem_ready_o);
    end
    tests_run++;
    if (m.mem_resp_exc_o !== exp_exc || m.mem_resp_exccode_o !== exp_code) begin
      tests_failed++;
      $display("FAIL resp addr=%h: got exc=%b code=%0d want exc=%b code=%0d",
               addr, m.mem_resp_exc_o, m.mem_resp_exccode_o, exp_exc, exp_code);
    end
    req0 = req_count; res0 = result_count;
    @(negedge clk);
    m.mem_valid_i = 0;
    res_c = -1;
    if (exp_exc) begin
      repeat (4) @(negedge clk);
      tests_run++;
      if (req_count != req0 || result_count != res0) begin
        tests_failed++;
        $display("FAIL exc_quiet addr=%h: got %0d reqs %0d results want 0 0",
                 addr, req_count - req0, result_count - res0);
      end
      $display("[TB] txn id=%0d addr=%h we=%0d size=%0d exception code=%0d", id, addr, we, size, exp_code);
    end else begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      exp_rdata = we ? 32'h0 : ref_mem[addr[9:2]];
      if (we) ref_mem[addr[9:2]] = (ref_mem[addr[9:2]] & ~mask) | (wdata & mask);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        if (m.mem_result_valid_o) seen = 1;
        else @(negedge clk);
      end
      res_c = cyc;
      tests_run++;
      if (!seen) begin
        tests_failed++; $display("FAIL result_timeout addr=%h: got no strobe want one", addr);
      end else begin
        tests_run++;
        if (res_c != hs_c + 3 + gd + rd) begin
          tests_failed++;
          $display("FAIL latency addr=%h: got %0d want %0d", addr, res_c - hs_c, 3 + gd + rd);
        end
        tests_run++;
        if (m.mem_result_id_o !== id || m.mem_result_rdata_o !== exp_rdata || m.mem_result_err_o !== err) begin
          tests_failed++;
          $display("FAIL result addr=%h: got id=%0d rdata=%h err=%b want id=%0d rdata=%h err=%b",
                   addr, m.mem_result_id_o, m.mem_result_rdata_o, m.mem_result_err_o, id, exp_rdata, err);
        end
      end
      $display("[TB] txn id=%0d addr=%h we=%0d size=%0d gd=%0d rd=%0d rdata=%h err=%0d",
               id, addr, we, size, gd, rd, m.mem_result_rdata_o, m.mem_result_err_o);
    end
  endtask

  task automatic test_reset;
    rst_n = 0; clear = 0;
    m.mem_valid_i = 1; m.mem_id_i = 0; m.mem_addr_i = 0; m.mem_we_i = 0;
    m.mem_size_i = 3'b100; m.mem_be_i = 4'hF; m.mem_wdata_i = 0; m.mem_last_i = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({m.mem_ready_o, m.data_req_o, m.mem_result_valid_o, m.mem_resp_exc_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready/req/res/exc=%b want 0000",
               {m.mem_ready_o, m.data_req_o, m.mem_result_valid_o, m.mem_resp_exc_o});
    end
    m.mem_valid_i = 0;
    rst_n = 1;
    @(negedge clk);
    tests_run++;
    if (m.mem_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL ready_after_reset: got %b want 1", m.mem_ready_o);
    end
  endtask

  task automatic test_directed;
    int rc;
    obi_mem[64] = 32'hDEADBEEF; ref_mem[64] = 32'hDEADBEEF;
    run_txn(4'd3, 32'h100, 1'b0, 3'b100, 4'hF, 32'h0, 0, 0, 1'b0, rc);
    run_txn(4'd4, 32'h104, 1'b1, 3'b100, 4'hF, 32'h12345678, 4, 0, 1'b0, rc);
    tests_run++;
    if (obi_mem[65] !== 32'h12345678 || stable_viol != 0) begin
      tests_failed++;
      $display("FAIL store_mem: got mem=%h unstable=%0d want 12345678 0", obi_mem[65], stable_viol);
    end
    run_txn(4'd5, 32'h102, 1'b0, 3'b100, 4'hF, 32'h0, 0, 0, 1'b0, rc);
    run_txn(4'd6, 32'h101, 1'b1, 3'b010, 4'h3, 32'hA5A5, 0, 0, 1'b0, rc);
    run_txn(4'd7, 32'h0020_0000, 1'b1, 3'b100, 4'hF, 32'hCAFEF00D, 0, 0, 1'b0, rc);
    run_txn(4'd9, 32'h200, 1'b0, 3'b100, 4'hF, 32'h0, 1, 2, 1'b1, rc);
  endtask

  task automatic test_clear;
    int g0, r0, v0, s0, n;
    clear = 1; #1;
    tests_run++;
    if (m.mem_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL clear_idle_ready: got %b want 0", m.mem_ready_o);
    end
    @(negedge clk);
    clear = 0;
    g0 = grant_count; r0 = result_count; v0 = rvalid_count; s0 = stable_viol;
    gnt_delay = 3; rvalid_delay = 1; err_inject = 0;
    m.mem_valid_i = 1; m.mem_id_i = 4'd6; m.mem_addr_i = 32'h80; m.mem_we_i = 0;
    m.mem_size_i = 3'b100; m.mem_be_i = 4'hF;
    @(negedge clk);
    m.mem_valid_i = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    tests_run++;
    if (m.data_req_o !== 1'b1) begin
      tests_failed++; $display("FAIL clear_req_held: got %b want 1", m.data_req_o);
    end
    n = 0;
    while (!m.mem_ready_o && n < 30) begin @(negedge clk); n++; end
    tests_run++;
    if (m.mem_ready_o !== 1'b1 || grant_count != g0 + 1 || rvalid_count != v0 + 1 || stable_viol != s0) begin
      tests_failed++;
      $display("FAIL clear_drain: got ready=%b grants=%0d rvalids=%0d unstable=%0d want 1 1 1 0",
               m.mem_ready_o, grant_count - g0, rvalid_count - v0, stable_viol - s0);
    end
    // Clear landing on the very cycle the response is captured.
    gnt_delay = 0; rvalid_delay = 0;
    m.mem_valid_i = 1; m.mem_addr_i = 32'h84;
    @(negedge clk);
    m.mem_valid_i = 0;
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (result_count != r0 || m.mem_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_results: got %0d results ready=%b want 0 1", result_count - r0, m.mem_ready_o);
    end
    $display("[TB] txn clear scenarios done");
  endtask

  task automatic test_reset_in_resp;
    int rc;
    gnt_delay = 0; rvalid_delay = 6; err_inject = 0;
    m.mem_valid_i = 1; m.mem_id_i = 4'd7; m.mem_addr_i = 32'h40; m.mem_we_i = 0;
    m.mem_size_i = 3'b100; m.mem_be_i = 4'hF;
    @(negedge clk);
    m.mem_valid_i = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests_run++;
    if ({m.mem_ready_o, m.data_req_o, m.mem_result_valid_o} !== 3'b000 || m.data_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_in_resp: got ready/req/res=%b addr=%h want 000 0",
               {m.mem_ready_o, m.data_req_o, m.mem_result_valid_o}, m.data_addr_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_txn(4'd8, 32'h40, 1'b0, 3'b100, 4'hF, 32'h0, 0, 0, 1'b0, rc);
  endtask

  task automatic test_back_to_back;
    int r1, r2, r3;
    run_txn(4'd1, 32'h10, 1'b1, 3'b100, 4'hF, $urandom, 0, 0, 1'b0, r1);
    run_txn(4'd2, 32'h10, 1'b0, 3'b100, 4'hF, 32'h0, 0, 0, 1'b0, r2);
    run_txn(4'd3, 32'h12, 1'b0, 3'b010, 4'h3, 32'h0, 0, 0, 1'b0, r3);
    tests_run++;
    if (r2 - r1 != 3 || r3 - r2 != 3) begin
      tests_failed++; $display("FAIL back_to_back: got spacing %0d %0d want 3 3", r2 - r1, r3 - r2);
    end
  endtask

  task automatic test_random;
    int rc, bad;
    logic [2:0] size;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: size = 3'b001;
        1: size = 3'b010;
        2: size = 3'b100;
        default: size = 3'b111;
      endcase
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h0030_0000;
      run_txn(4'($urandom), addr, 1'($urandom), size, 4'($urandom), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), rc);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (obi_mem[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL memory_image: got %0d differing words want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      obi_mem[i] = $urandom;
      ref_mem[i] = obi_mem[i];
    end
    test_reset();
    test_directed();
    test_clear();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    tests_run++;
    if (double_pulse != 0 || align_viol != 0) begin
      tests_failed++;
      $display("FAIL strobe_align: got %0d long strobes %0d unaligned want 0 0", double_pulse, align_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_xifu_mem_responder.md
# fir_xifu_mem_responder

Core-side responder for the CORE-V-XIF memory interface used by the FIR XIFU's `xfirlw`/`xfirsw` instructions. It accepts one coprocessor memory request at a time, answers `mem_resp` during the handshake, and performs the access on an OBI data port. It then returns `mem_result` to the coprocessor. It sits between the FIR XIFU and data memory in standalone/integration testbenches, and in SoCs where the coprocessor owns a private OBI port.

## Interface

**Parameters**
- `X_ID_WIDTH`, 4: width of the instruction id field.
- `ADDR_BASE`, 32'h0000_0000: first legal byte address. Used only when the PMA check is compiled in.
- `ADDR_SIZE`, 32'h0010_0000: size of the legal region in bytes.

**Ports**
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `clear_i`, in, 1: synchronous soft clear.
- `mem_valid_i`, in, 1: coprocessor memory request valid.
- `mem_ready_o`, out, 1: responder can accept a request.
- `mem_id_i`, in, X_ID_WIDTH: instruction id.
- `mem_addr_i`, in, 32: byte address.
- `mem_we_i`, in, 1: 1 means store.
- `mem_size_i`, in, 3: access size, 3'b001 byte, 3'b010 half, 3'b100 word.
- `mem_be_i`, in, 4: byte enables.
- `mem_wdata_i`, in, 32: store data.
- `mem_last_i`, in, 1: last request of the instruction. Ignored.
- `mem_resp_exc_o`, out, 1: synchronous exception. Valid during the handshake.
- `mem_resp_exccode_o`, out, 6: exception code.
- `mem_result_valid_o`, out, 1: one-cycle result strobe.
- `mem_result_id_o`, out, X_ID_WIDTH: id of the completed request.
- `mem_result_rdata_o`, out, 32: load data. 0 for stores.
- `mem_result_err_o`, out, 1: bus error reported by OBI.
- `data_req_o`, out, 1: OBI request.
- `data_gnt_i`, in, 1: OBI grant.
- `data_addr_o`, out, 32: OBI address. Word-aligned.
- `data_we_o`, out, 1: OBI write enable.
- `data_be_o`, out, 4: OBI byte enables.
- `data_wdata_o`, out, 32: OBI write data.
- `data_rvalid_i`, in, 1: OBI response valid.
- `data_rdata_i`, in, 32: OBI read data.
- `data_err_i`, in, 1: OBI error.

## Operation

**Handshake and exception check**
- The FSM has four states: IDLE, REQ, RESP, DRAIN.
- `mem_ready_o` is 1 only in IDLE with `clear_i` low.
- A handshake occurs when `mem_valid_i & mem_ready_o`.
- The exception check is combinational on the request inputs and is evaluated during the handshake cycle. Checks, in priority order:
  - Misalignment: the access is misaligned if the size is word and `addr[1:0] != 0`, or the size is half and `addr[0]`. The code is 6 for a store, 4 for a load.
  - Out of region (PMA check, see Configuration): the code is 7 for a store, 5 for a load.
  - Any other size encoding is treated as a word access.
- On an exception:
  - `mem_resp_exc_o` = 1 and `mem_resp_exccode_o` = the code.
  - No OBI transaction is issued, no `mem_result` is produced, and the FSM stays in IDLE.
- Outside the handshake, `mem_resp_*` outputs are 0.

**Transaction path**
- On a handshake with no exception, the request fields are registered and the FSM goes IDLE→REQ.
- REQ:
  - `data_req_o` = 1, with address `{addr[31:2],2'b00}`, the registered `we`/`be`/`wdata`.
  - `data_req_o` and all attributes are held stable until `data_gnt_i`.
  - On `data_gnt_i`, the FSM goes to RESP.
- RESP:
  - On `data_rvalid_i`, register the result:
    - `rdata` = `data_rdata_i` for a load, 0 for a store.
    - `err` = `data_err_i`.
    - `id` = the registered id.
  - Pulse `mem_result_valid_o` for exactly one cycle on the next cycle, then return to IDLE.
- A new request is accepted in the same cycle the result strobe is high.

**Clear and reset**
- `clear_i` in IDLE: no effect beyond forcing `mem_ready_o` low.
- `clear_i` in REQ: the request is not retracted (OBI rule). On grant the FSM goes to DRAIN instead of RESP.
- `clear_i` in RESP: the FSM goes to DRAIN.
- DRAIN: wait for `data_rvalid_i`, discard the data, suppress `mem_result`, then go to IDLE.
- A clear that arrives in the same cycle as a result capture cancels that result.
- Asynchronous reset at any point returns the FSM to IDLE immediately. Any outstanding OBI response is ignored.

## Timing

- All outputs reset to 0, including `mem_ready_o`. `mem_ready_o` rises in the first cycle after reset is released.
- Latency, with handshake at cycle 0:
  - `data_req_o` at cycle 1.
  - With grant at cycle 1, rvalid at cycle 2 at the earliest.
  - `mem_result_valid_o` at cycle 3.
- Each wait cycle on grant or rvalid adds one cycle.
- Throughput: at most one transaction per 3 cycles. Only one transaction is outstanding.
- `mem_resp_*` outputs are combinational from request inputs. All other outputs are registered.

## Configuration

- Macro: `FIR_XIFU_MEM_RESP_PMA_EN`.
- Defined: a word-aligned address outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) raises an access fault with code 5 (load) or 7 (store).
- Undefined: all aligned addresses are legal, and `ADDR_BASE`/`ADDR_SIZE` are unused.

## Test plan

- Aligned load, id 3, addr 0x100, memory holds 0xDEADBEEF, immediate grant, rvalid one cycle later:
  - no exception;
  - `mem_result_valid_o` for one cycle at cycle 3, id 3, rdata 0xDEADBEEF, err 0.
- Store, addr 0x104, wdata 0x12345678, be 4'b1111, grant delayed 4 cycles:
  - `data_req_o` and attributes are stable until grant;
  - result has rdata 0 and the memory word is updated.
- Misaligned word load at addr 0x102:
  - `mem_resp_exc_o` = 1 with code 4 in the handshake cycle;
  - `data_req_o` stays 0 and there is no result.
- With `FIR_XIFU_MEM_RESP_PMA_EN`, store at 0x0020_0000 with the default region:
  - code 7 and no OBI activity.
- Without the macro, the same store completes on OBI.
- `clear_i` pulsed while in REQ awaiting grant:
  - the request is held until grant;
  - the response is drained and no `mem_result_valid_o` occurs;
  - `mem_ready_o` returns high after the response.
- Load whose OBI response carries `data_err_i` = 1:
  - `mem_result_err_o` = 1 with the correct id.
- Reset asserted in RESP:
  - all outputs go to 0 immediately;
  - a subsequent request completes normally.
